// File: rtl/soc_system_key_pkg.sv
// rtl/soc_system_key_pkg.sv - shared defaults and width helper for the key debouncer
package soc_system_key_pkg;

   localparam int KEY_WIDTH        = 14;
   localparam int KEY_TICK_DIV     = 50000;
   localparam int KEY_STABLE_TICKS = 16;

   // Ceiling log2, never below 1 so degenerate counters still get a bit.
   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/soc_system_key_debounce_if.sv
// rtl/soc_system_key_debounce_if.sv - raw key pins in, debounced levels and strobes out
interface soc_system_key_debounce_if import soc_system_key_pkg::*; #(
   parameter int WIDTH = KEY_WIDTH
);
   logic [WIDTH-1:0] key_raw;
   logic [WIDTH-1:0] key_out;
   logic [WIDTH-1:0] key_changed;
   logic             tick;

   modport master (output key_raw, input key_out, input key_changed, input tick);
   modport slave  (input key_raw, output key_out, output key_changed, output tick);
endinterface

// File: rtl/soc_system_key_debounce_chan.sv
// rtl/soc_system_key_debounce_chan.sv - one key bit: 2-flop sync, stable-tick counter, output flop
module soc_system_key_debounce_chan import soc_system_key_pkg::*; #(
   parameter int   STABLE_TICKS = KEY_STABLE_TICKS,
   parameter logic RESET_BIT    = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic raw,
   output logic key_out,
   output logic key_changed
);
   localparam int            CW       = clog2_min1(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          sync1_q, sync2_q;
   logic          key_q, key_d;
   logic          chg_q, chg_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A match on any cycle, tick or not, restarts the count so bounces never accumulate.
   always_comb begin
      key_d = key_q;
      chg_d = 1'b0;
      cnt_d = cnt_q;
      if (sync2_q == key_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == CNT_LAST) begin
            key_d = sync2_q;
            chg_d = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_BIT;
         sync2_q <= RESET_BIT;
         key_q   <= RESET_BIT;
         chg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         key_q   <= key_d;
         chg_q   <= chg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_out     = key_q;
   assign key_changed = chg_q;

endmodule

// File: rtl/soc_system_key_debounce.sv
// rtl/soc_system_key_debounce.sv - shared sample-tick prescaler feeding WIDTH debounce channels
module soc_system_key_debounce import soc_system_key_pkg::*; #(
   parameter int               WIDTH        = KEY_WIDTH,
   parameter int               TICK_DIV     = KEY_TICK_DIV,
   parameter int               STABLE_TICKS = KEY_STABLE_TICKS,
   parameter logic [WIDTH-1:0] RESET_LEVEL  = {WIDTH{1'b1}}
) (
   input  logic                      clk,
   input  logic                      reset_n,
   soc_system_key_debounce_if.slave  key_if
);
   localparam int            DW      = clog2_min1(TICK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          run_q;
   logic          wrap_w;
   logic          tick_w;

   // run_q keeps tick low while in reset even when TICK_DIV is 1.
   assign wrap_w    = (div_cnt_q == DIV_MAX);
   assign tick_w    = wrap_w & run_q;
   assign div_cnt_d = wrap_w ? '0 : div_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
         run_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         run_q     <= 1'b1;
      end
   end

   assign key_if.tick = tick_w;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      soc_system_key_debounce_chan #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_BIT    (RESET_LEVEL[g])
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .tick        (tick_w),
         .raw         (key_if.key_raw[g]),
         .key_out     (key_if.key_out[g]),
         .key_changed (key_if.key_changed[g])
      );
   end

endmodule

// File: tb/tb_soc_system_key_debounce.sv
// tb/tb_soc_system_key_debounce.sv - self-checking bench with a stable-run model of the debouncer
module tb_soc_system_key_debounce;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   soc_system_key_debounce_if #(.WIDTH(14)) if_a ();
   soc_system_key_debounce_if #(.WIDTH(14)) if_b ();

   soc_system_key_debounce #(.WIDTH(14), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_LEVEL(14'h3FFF))
      dut_a (.clk(clk), .reset_n(rst_a), .key_if(if_a));
   soc_system_key_debounce #(.WIDTH(14), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_LEVEL(14'h3FFF))
      dut_b (.clk(clk), .reset_n(rst_b), .key_if(if_b));

   typedef struct packed {
      logic [13:0]       s1;
      logic [13:0]       s2;
      logic [13:0]       out;
      logic [13:0]       chg;
      logic [31:0]       k;
      logic [13:0][31:0] mm;
   } mstate_t;

   mstate_t ma, mb;

   function automatic bit tick_of(input int k, input int td);
      return (k >= 1) && (k % td == td - 1);
   endfunction

   function automatic int ticks_in(input int a, input int b, input int td);
      int c;
      c = 0;
      for (int j = a; j <= b; j++) if (tick_of(j, td)) c++;
      return c;
   endfunction

   function automatic mstate_t mreset();
      mstate_t r;
      r.s1 = 14'h3FFF; r.s2 = 14'h3FFF; r.out = 14'h3FFF; r.chg = '0; r.k = '0; r.mm = '1;
      return r;
   endfunction

   // A bit flips when the synchronised input has disagreed with the output across st ticks.
   function automatic mstate_t mstep(input mstate_t s, input logic [13:0] raw, input int td, input int st);
      mstate_t n;
      int      k;
      int      start;
      bit      t;
      n = s;
      k = int'(s.k);
      t = tick_of(k, td);
      n.chg = '0;
      for (int i = 0; i < 14; i++) begin
         if (s.s2[i] == s.out[i]) begin
            n.mm[i] = '1;
         end else begin
            start = (s.mm[i] == '1) ? k : int'(s.mm[i]);
            if (t && ticks_in(start, k, td) == st) begin
               n.out[i] = s.s2[i];
               n.chg[i] = 1'b1;
               n.mm[i]  = '1;
            end else begin
               n.mm[i] = start;
            end
         end
      end
      n.s2 = s.s1;
      n.s1 = raw;
      n.k  = s.k + 1;
      return n;
   endfunction

   always @(posedge clk or negedge rst_a)
      if (!rst_a) ma = mreset();
      else        ma = mstep(ma, if_a.key_raw, 4, 3);

   always @(posedge clk or negedge rst_b)
      if (!rst_b) mb = mreset();
      else        mb = mstep(mb, if_b.key_raw, 1, 1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_out_a", 32'(if_a.key_out), 32'(ma.out));
      check("model_chg_a", 32'(if_a.key_changed), 32'(ma.chg));
      check("model_tick_a", 32'(if_a.tick), 32'(tick_of(int'(ma.k), 4)));
      check("model_out_b", 32'(if_b.key_out), 32'(mb.out));
      check("model_chg_b", 32'(if_b.key_changed), 32'(mb.chg));
      check("model_tick_b", 32'(if_b.tick), 32'(tick_of(int'(mb.k), 1)));
   end

   // Runs 30 cycles; reports the first cycle bit b reaches val plus the vectors seen then.
   task automatic measure(input int d, input int b, input logic val, output int cyc,
                          output int pulses, output logic [13:0] chg_v, output logic [13:0] out_v);
      logic [13:0] o, c;
      cyc = 0; pulses = 0; chg_v = '0; out_v = '0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         o = (d == 0) ? if_a.key_out : if_b.key_out;
         c = (d == 0) ? if_a.key_changed : if_b.key_changed;
         pulses += int'(c[b]);
         if (cyc == 0 && o[b] == val) begin
            cyc = n; chg_v = c; out_v = o;
         end
      end
   endtask

   initial begin
      int          cyc, pulses, ticks_a, ticks_b;
      logic [13:0] cv, ov, seen_chg;
      logic        flipped;
      if_a.key_raw = 14'h3FFF;
      if_b.key_raw = 14'h3FFF;
      #1 rst_a = 1'b0; rst_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", 32'(if_a.key_out), 32'h3FFF);
      check("reset_chg", 32'(if_a.key_changed), 32'h0);
      check("reset_tick_a", 32'(if_a.tick), 32'h0);
      check("reset_tick_b", 32'(if_b.tick), 32'h0);
      rst_a = 1'b1; rst_b = 1'b1;

      ticks_a = 0; ticks_b = 0; seen_chg = '0;
      repeat (100) begin
         @(posedge clk); #1;
         ticks_a += int'(if_a.tick);
         ticks_b += int'(if_b.tick);
         seen_chg |= if_a.key_changed;
      end
      check("idle_ticks_a", 32'(ticks_a), 32'd25);
      check("idle_ticks_b", 32'(ticks_b), 32'd100);
      check("idle_out", 32'(if_a.key_out), 32'h3FFF);
      check("idle_chg", 32'(seen_chg), 32'h0);

      if_a.key_raw[0] = 1'b0;
      measure(0, 0, 1'b0, cyc, pulses, cv, ov);
      check("press_latency_in_11_14", 32'(cyc >= 11 && cyc <= 14), 32'd1);
      check("press_pulses", 32'(pulses), 32'd1);
      check("press_chg", 32'(cv), 32'h0001);
      check("press_out", 32'(ov), 32'h3FFE);
      if_a.key_raw[0] = 1'b1;
      measure(0, 0, 1'b1, cyc, pulses, cv, ov);
      check("release_out", 32'(ov), 32'h3FFF);

      flipped = 1'b0; seen_chg = '0;
      for (int seg = 0; seg < 12; seg++) begin
         if_a.key_raw[3] = (seg % 2 == 0) ? 1'b0 : 1'b1;
         repeat (5) begin
            @(posedge clk); #1;
            flipped |= ~if_a.key_out[3];
            seen_chg |= if_a.key_changed;
         end
      end
      check("bounce_held", 32'(flipped), 32'd0);
      check("bounce_no_chg", 32'(seen_chg), 32'h0);
      if_a.key_raw[3] = 1'b0;
      measure(0, 3, 1'b0, cyc, pulses, cv, ov);
      check("settle_latency_in_11_14", 32'(cyc >= 11 && cyc <= 14), 32'd1);
      check("settle_pulses", 32'(pulses), 32'd1);
      if_a.key_raw[3] = 1'b1;
      measure(0, 3, 1'b1, cyc, pulses, cv, ov);

      if_a.key_raw = 14'h3FF0;
      measure(0, 0, 1'b0, cyc, pulses, cv, ov);
      check("simul_chg", 32'(cv), 32'h000F);
      check("simul_out", 32'(ov), 32'h3FF0);
      if_a.key_raw = 14'h3FFF;
      measure(0, 0, 1'b1, cyc, pulses, cv, ov);
      check("simul_release_chg", 32'(cv), 32'h000F);

      if_a.key_raw[5] = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst_a = 1'b0;
      #1;
      check("midreset_out", 32'(if_a.key_out), 32'h3FFF);
      check("midreset_chg", 32'(if_a.key_changed), 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b1;
      measure(0, 5, 1'b0, cyc, pulses, cv, ov);
      check("midreset_latency_in_11_14", 32'(cyc >= 11 && cyc <= 14), 32'd1);
      check("midreset_chg_vec", 32'(cv), 32'h0020);

      if_b.key_raw[13] = 1'b0;
      measure(1, 13, 1'b0, cyc, pulses, cv, ov);
      check("corner_latency", 32'(cyc), 32'd3);
      check("corner_chg", 32'(cv), 32'h2000);
      check("corner_pulses", 32'(pulses), 32'd1);

      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

endmodule
